mul_issue_ctrl: RTL and testbench

- Front-end controller for the combinational 32x32 tree multiplier.
- Arbitrates round-robin between NUM_REQ issue ports and registers the chosen operands into an operand stage (S1) that drives the multiplier.
- Captures the selected 32-bit half of the 64-bit product in a result stage (S2) and returns it with a valid/ready handshake.
- Supports pipeline flush and flags illegal func3 encodings.

---
 rtl/mul_issue_ctrl_if.sv | 41 ++++
 rtl/mul_issue_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_issue_ctrl_if.sv
// Bundle between the multiplier issue controller and its surroundings: issue ports,
// flush, multiplier operand/result wires and the result return channel.
interface mul_issue_ctrl_if #(
   parameter int NUM_REQ = 2,
   parameter int TAG_W   = 5,
   parameter int SRC_W   = $clog2(NUM_REQ)
);
   // Handshakes (req_valid/req_ready per port, out_valid/out_ready): a transfer occurs
   // at the rising edge where valid and ready are both high; valid never depends on
   // ready, and the producer holds valid and payload stable until the transfer.
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*32-1:0]    req_op1;
   logic [NUM_REQ*32-1:0]    req_op2;
   logic [NUM_REQ*3-1:0]     req_func3;
   logic [NUM_REQ*TAG_W-1:0] req_tag;
   logic                     flush;
   logic [31:0]              mul_op1;
   logic [31:0]              mul_op2;
   logic [2:0]               mul_func3;
   logic [63:0]              mul_result;
   logic                     out_valid;
   logic                     out_ready;
   logic [31:0]              out_data;
   logic [TAG_W-1:0]         out_tag;
   logic [SRC_W-1:0]         out_src;
   logic                     out_err;
   logic                     busy;

   modport slave (
      input  req_valid, req_op1, req_op2, req_func3, req_tag, flush, mul_result, out_ready,
      output req_ready, mul_op1, mul_op2, mul_func3, out_valid, out_data, out_tag, out_src,
             out_err, busy
   );

   modport master (
      output req_valid, req_op1, req_op2, req_func3, req_tag, flush, mul_result, out_ready,
      input  req_ready, mul_op1, mul_op2, mul_func3, out_valid, out_data, out_tag, out_src,
             out_err, busy
   );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Round-robin issue front end for a combinational 32x32 multiplier: S1 holds the operands
// that drive the multiplier, S2 captures the selected product half for the consumer.
module mul_issue_ctrl #(
   parameter int NUM_REQ = 2,
   parameter int TAG_W   = 5,
   parameter int SRC_W   = $clog2(NUM_REQ)
) (
   input logic         clk,
   input logic         rst,
   mul_issue_ctrl_if.slave bus
);
   logic [SRC_W-1:0]   ptr_q, ptr_d;
   logic               s1_valid_q, s1_valid_d;
   logic [31:0]        s1_op1_q, s1_op1_d;
   logic [31:0]        s1_op2_q, s1_op2_d;
   logic [2:0]         s1_func3_q, s1_func3_d;
   logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
   logic [SRC_W-1:0]   s1_src_q, s1_src_d;
   logic               s2_valid_q, s2_valid_d;
   logic [31:0]        s2_data_q, s2_data_d;
   logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;
   logic [SRC_W-1:0]   s2_src_q, s2_src_d;
   logic               s2_err_q, s2_err_d;

   logic               s1_adv, s2_adv, accept, grant_any;
   logic [SRC_W-1:0]   grant_idx;
   logic [NUM_REQ-1:0] grant_vec;
   logic [31:0]        g_op1, g_op2, sel_data;
   logic [2:0]         g_func3;
   logic [TAG_W-1:0]   g_tag;
   logic               sel_err;

   assign s2_adv = !s2_valid_q | bus.out_ready;
   assign s1_adv = !s1_valid_q | s2_adv;
   assign accept = grant_any & s1_adv & !bus.flush;

   // Search starts at ptr and wraps; the first requesting port wins.
   always_comb begin
      int sum;
      sum       = 0;
      grant_any = 1'b0;
      grant_idx = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         sum = int'(ptr_q) + off;
         if (sum >= NUM_REQ) sum = sum - NUM_REQ;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!grant_any && (j == sum) && bus.req_valid[j]) begin
               grant_any = 1'b1;
               grant_idx = SRC_W'(j);
            end
         end
      end
   end

   always_comb begin
      grant_vec = '0;
      g_op1     = '0;
      g_op2     = '0;
      g_func3   = '0;
      g_tag     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_vec[i] = grant_any && (grant_idx == SRC_W'(i));
         if (grant_vec[i]) begin
            g_op1   = bus.req_op1[i*32 +: 32];
            g_op2   = bus.req_op2[i*32 +: 32];
            g_func3 = bus.req_func3[i*3 +: 3];
            g_tag   = bus.req_tag[i*TAG_W +: TAG_W];
         end
      end
   end

   assign bus.req_ready = grant_vec & {NUM_REQ{s1_adv & !bus.flush}};

   // Half selection only; signedness is already resolved inside the multiplier.
   always_comb begin
      sel_data = '0;
      sel_err  = 1'b0;
      case (s1_func3_q)
         3'b000:                 sel_data = bus.mul_result[31:0];
         3'b001, 3'b010, 3'b011: sel_data = bus.mul_result[63:32];
         default:                sel_err  = 1'b1;
      endcase
   end

   always_comb begin
      ptr_d      = ptr_q;
      s1_valid_d = s1_valid_q;
      s1_op1_d   = s1_op1_q;
      s1_op2_d   = s1_op2_q;
      s1_func3_d = s1_func3_q;
      s1_tag_d   = s1_tag_q;
      s1_src_d   = s1_src_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_tag_d   = s2_tag_q;
      s2_src_d   = s2_src_q;
      s2_err_d   = s2_err_q;
      if (bus.flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
               s2_data_d = sel_data;
               s2_err_d  = sel_err;
               s2_tag_d  = s1_tag_q;
               s2_src_d  = s1_src_q;
            end
         end
         if (s1_adv) begin
            s1_valid_d = accept;
            if (accept) begin
               s1_op1_d   = g_op1;
               s1_op2_d   = g_op2;
               s1_func3_d = g_func3;
               s1_tag_d   = g_tag;
               s1_src_d   = grant_idx;
               ptr_d      = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_op1_q   <= '0;
         s1_op2_q   <= '0;
         s1_func3_q <= '0;
         s1_tag_q   <= '0;
         s1_src_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_tag_q   <= '0;
         s2_src_q   <= '0;
         s2_err_q   <= 1'b0;
      end else begin
         ptr_q      <= ptr_d;
         s1_valid_q <= s1_valid_d;
         s1_op1_q   <= s1_op1_d;
         s1_op2_q   <= s1_op2_d;
         s1_func3_q <= s1_func3_d;
         s1_tag_q   <= s1_tag_d;
         s1_src_q   <= s1_src_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_tag_q   <= s2_tag_d;
         s2_src_q   <= s2_src_d;
         s2_err_q   <= s2_err_d;
      end
   end

   assign bus.mul_op1   = s1_op1_q;
   assign bus.mul_op2   = s1_op2_q;
   assign bus.mul_func3 = s1_func3_q;
   assign bus.out_valid = s2_valid_q;
   assign bus.out_data  = s2_data_q;
   assign bus.out_tag   = s2_tag_q;
   assign bus.out_src   = s2_src_q;
   assign bus.out_err   = s2_err_q;
   assign bus.busy      = s1_valid_q | s2_valid_q;
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: behavioural multiplier, vector table, scoreboard of expected
// results and directed sequences for arbitration, backpressure and flush.
module tb_mul_issue_ctrl;
   localparam int NUM_REQ = 2;
   localparam int TAG_W   = 5;
   localparam int SRC_W   = 1;
   localparam int EW      = 1 + SRC_W + TAG_W + 32;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mul_issue_ctrl_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .SRC_W(SRC_W)) bus ();
   mul_issue_ctrl #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .SRC_W(SRC_W)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   function automatic logic [63:0] ref_prod(logic [31:0] a, logic [31:0] b, logic [2:0] f);
      logic signed [63:0] sa, sb;
      sa = {{32{a[31]}}, a};
      sb = (f[1:0] == 2'b10) ? $signed({32'b0, b}) : $signed({{32{b[31]}}, b});
      if (f[1:0] == 2'b11) return {32'b0, a} * {32'b0, b};
      return sa * sb;
   endfunction

   function automatic logic [EW-1:0] exp_word(logic [31:0] a, logic [31:0] b, logic [2:0] f,
                                              logic [TAG_W-1:0] t, logic [SRC_W-1:0] s);
      logic [63:0] p;
      logic [31:0] d;
      p = ref_prod(a, b, f);
      d = f[2] ? 32'h0 : ((f == 3'b000) ? p[31:0] : p[63:32]);
      return {f[2], s, t, d};
   endfunction

   assign bus.mul_result = ref_prod(bus.mul_op1, bus.mul_op2, bus.mul_func3);

   logic [EW-1:0]    exp_q[$];
   int               out_cyc_q[$];
   int               grant_log[$];
   logic [SRC_W-1:0] src_q[$];

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   // Scoreboard: outputs are popped before this cycle's accepts are pushed.
   always @(negedge clk) begin
      if (!rst) begin
         check("ready_onehot", 64'($onehot0(bus.req_ready)), 64'd1);
         check("ready_without_valid", 64'(bus.req_ready & ~bus.req_valid), 64'd0);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_out: got 0x%0h expected no result", bus.out_data);
            end else begin
               check("scoreboard", {bus.out_err, bus.out_src, bus.out_tag, bus.out_data},
                     exp_q.pop_front());
            end
            out_cyc_q.push_back(cyc);
            src_q.push_back(bus.out_src);
         end
         if (bus.flush) exp_q.delete();
         for (int p = 0; p < NUM_REQ; p++) begin
            if (bus.req_valid[p] && bus.req_ready[p]) begin
               exp_q.push_back(exp_word(bus.req_op1[p*32 +: 32], bus.req_op2[p*32 +: 32],
                                        bus.req_func3[p*3 +: 3], bus.req_tag[p*TAG_W +: TAG_W],
                                        SRC_W'(p)));
               grant_log.push_back(p);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(int p, logic [31:0] a, logic [31:0] b, logic [2:0] f,
                           logic [TAG_W-1:0] t);
      bus.req_valid[p]           = 1'b1;
      bus.req_op1[p*32 +: 32]    = a;
      bus.req_op2[p*32 +: 32]    = b;
      bus.req_func3[p*3 +: 3]    = f;
      bus.req_tag[p*TAG_W +: TAG_W] = t;
   endtask

   task automatic issue(int p, logic [31:0] a, logic [31:0] b, logic [2:0] f,
                        logic [TAG_W-1:0] t, output int acc);
      set_port(p, a, b, f, t);
      acc = -1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.req_ready[p]) begin
            acc = cyc;
            break;
         end
      end
      if (acc < 0) timeout("issue_accept");
      tick();
      bus.req_valid[p] = 1'b0;
   endtask

   task automatic wait_out(output int c);
      c = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) timeout("wait_out_valid");
   endtask

   task automatic drain();
      for (int k = 0; k < 40; k++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_op1   = '0;
      bus.req_op2   = '0;
      bus.req_func3 = '0;
      bus.req_tag   = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) tick();
      exp_q.delete();
      out_cyc_q.delete();
      grant_log.delete();
      src_q.delete();
      rst = 1'b0;
   endtask

   typedef struct {
      int               port;
      logic [31:0]      op1;
      logic [31:0]      op2;
      logic [2:0]       f3;
      logic [TAG_W-1:0] tag;
      logic [31:0]      exp_data;
      logic             exp_err;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int acc, oc;
      logic [31:0] held;
      vecs[0] = '{0, 32'hFFFF_FFF9, 32'd3,        3'b000, 5'd4,  32'hFFFF_FFEB, 1'b0};
      vecs[1] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 5'd1,  32'hFFFF_FFFE, 1'b0};
      vecs[2] = '{1, 32'h8000_0000, 32'h8000_0000, 3'b001, 5'd2,  32'h4000_0000, 1'b0};
      vecs[3] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 5'd3,  32'hFFFF_FFFF, 1'b0};
      vecs[4] = '{1, 32'h1234_5678, 32'd9,        3'b101, 5'd5,  32'h0,         1'b1};
      vecs[5] = '{1, 32'd5,         32'd7,        3'b000, 5'd6,  32'h23,        1'b0};
      vecs[6] = '{0, 32'h1234_5678, 32'h10,       3'b011, 5'd7,  32'h1,         1'b0};
      vecs[7] = '{1, 32'h1234_5678, 32'h10,       3'b000, 5'd8,  32'h2345_6780, 1'b0};
      vecs[8] = '{0, 32'd3,         32'd3,        3'b111, 5'd31, 32'h0,         1'b1};

      do_reset();
      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data", 64'(bus.out_data), 64'd0);
      check("rst_out_tag", 64'(bus.out_tag), 64'd0);
      check("rst_out_src", 64'(bus.out_src), 64'd0);
      check("rst_out_err", 64'(bus.out_err), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_mul_op1", 64'(bus.mul_op1), 64'd0);
      check("rst_mul_func3", 64'(bus.mul_func3), 64'd0);
      tick();

      for (int i = 0; i < 9; i++) begin
         issue(vecs[i].port, vecs[i].op1, vecs[i].op2, vecs[i].f3, vecs[i].tag, acc);
         wait_out(oc);
         check("vec_latency", 64'(oc - acc), 64'd2);
         check("vec_data", 64'(bus.out_data), 64'(vecs[i].exp_data));
         check("vec_err", 64'(bus.out_err), 64'(vecs[i].exp_err));
         check("vec_tag", 64'(bus.out_tag), 64'(vecs[i].tag));
         check("vec_src", 64'(bus.out_src), 64'(vecs[i].port));
         tick();
      end
      drain();

      // Three high-half products back to back must come out on consecutive cycles.
      out_cyc_q.delete();
      issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 5'd9, acc);
      issue(0, 32'h8000_0000, 32'h8000_0000, 3'b001, 5'd10, acc);
      issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 5'd11, acc);
      drain();
      check("b2b_count", 64'(out_cyc_q.size()), 64'd3);
      check("b2b_gap0", 64'(out_cyc_q[1] - out_cyc_q[0]), 64'd1);
      check("b2b_gap1", 64'(out_cyc_q[2] - out_cyc_q[1]), 64'd1);

      // Two ports requesting continuously from reset alternate grants.
      do_reset();
      set_port(0, 32'd2, 32'd3, 3'b000, 5'd12);
      set_port(1, 32'h7000_0000, 32'd16, 3'b011, 5'd13);
      repeat (6) tick();
      bus.req_valid = '0;
      drain();
      check("rr_grants", 64'(grant_log.size()), 64'd6);
      check("rr_outputs", 64'(src_q.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         check("rr_grant_seq", 64'(grant_log[i]), 64'(i % 2));
         check("rr_src_seq", 64'(src_q[i]), 64'(i % 2));
      end

      // Port-0 stream with the consumer stalled for three cycles.
      out_cyc_q.delete();
      fork
         begin
            for (int i = 0; i < 6; i++)
               issue(0, 32'(i + 1) * 32'h0101_0101, 32'h100 + 32'(i), 3'b000, 5'(i), acc);
         end
         begin
            tick();
            tick();
            bus.out_ready = 1'b0;
            @(negedge clk);
            held = bus.out_data;
            check("bp_valid_held", 64'(bus.out_valid), 64'd1);
            tick();
            @(negedge clk);
            check("bp_data_stable1", 64'(bus.out_data), 64'(held));
            tick();
            @(negedge clk);
            check("bp_data_stable2", 64'(bus.out_data), 64'(held));
            check("bp_ready_low", 64'(bus.req_ready), 64'd0);
            check("bp_busy", 64'(bus.busy), 64'd1);
            tick();
            bus.out_ready = 1'b1;
         end
      join
      drain();
      check("bp_result_count", 64'(out_cyc_q.size()), 64'd6);

      // Flush with both stages full and a request waiting.
      bus.out_ready = 1'b0;
      issue(0, 32'd11, 32'd12, 3'b000, 5'd20, acc);
      issue(1, 32'd13, 32'd14, 3'b000, 5'd21, acc);
      set_port(0, 32'd15, 32'd16, 3'b000, 5'd22);
      bus.flush = 1'b1;
      @(negedge clk);
      check("flush_ready", 64'(bus.req_ready), 64'd0);
      check("flush_busy_before", 64'(bus.busy), 64'd1);
      tick();
      bus.flush        = 1'b0;
      bus.req_valid[0] = 1'b0;
      @(negedge clk);
      check("flush_out_valid", 64'(bus.out_valid), 64'd0);
      check("flush_busy_after", 64'(bus.busy), 64'd0);
      tick();
      bus.out_ready = 1'b1;
      issue(0, 32'd9, 32'd9, 3'b000, 5'd23, acc);
      wait_out(oc);
      check("post_flush_data", 64'(bus.out_data), 64'd81);
      check("post_flush_tag", 64'(bus.out_tag), 64'd23);
      tick();
      drain();

      // Flush in the same cycle as an output handshake: that result is delivered, S1 dies.
      out_cyc_q.delete();
      issue(0, 32'd4, 32'd5, 3'b000, 5'd24, acc);
      issue(0, 32'd6, 32'd7, 3'b000, 5'd25, acc);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      repeat (4) tick();
      @(negedge clk);
      check("flush_hs_out_valid", 64'(bus.out_valid), 64'd0);
      check("flush_hs_count", 64'(out_cyc_q.size()), 64'd1);
      tick();

      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
